// File: rtl/dram_sim2.sv
// dram_sim2: cycle-accurate stand-in for the DRAMSim2 memory model.
// Requests are queued in order and serviced one at a time with a fixed
// per-type latency; each completion produces a one-cycle TX_COMP pulse
// carrying the completed address and type.
// Optional feature: define DRAMSIM2_REFRESH_EN to add periodic refresh stalls.
module dram_sim2 #(
    parameter int ADDR_W       = 64,
    parameter int DEPTH        = 4,
    parameter int READ_LAT     = 10,
    parameter int WRITE_LAT    = 6,
    parameter int REF_INTERVAL = 64,
    parameter int REF_CYCLES   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              TX_ENQ,
    input  logic              IS_WR,
    input  logic [ADDR_W-1:0] ADDR,
    output logic              TX_COMP,
    output logic              IS_WR_OUT,
    output logic [ADDR_W-1:0] ADDR_OUT,
    output logic              FULL
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
`ifdef DRAMSIM2_REFRESH_EN
    localparam logic [1:0] ST_REFRESH = 2'd2;
    localparam int RT_W = $clog2(REF_INTERVAL + 1);
    localparam int RC_W = $clog2(REF_CYCLES + 1);
`endif

    // Elaboration-time parameter sanity checks.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dram_sim2: DEPTH must be a power of two >= 2");
    end
    if ((READ_LAT < 2) || (WRITE_LAT < 2)) begin : g_bad_lat
        $error("dram_sim2: READ_LAT and WRITE_LAT must be >= 2");
    end
    if ((REF_INTERVAL < 1) || (REF_CYCLES < 1)) begin : g_bad_ref
        $error("dram_sim2: REF_INTERVAL and REF_CYCLES must be >= 1");
    end

    // Entry storage; the head entry stays here while it is in service.
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic              wr_mem_q   [DEPTH];

    logic [1:0]        state_q,    state_d;
    logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic              tx_comp_q,  tx_comp_d;
    logic              is_wr_out_q, is_wr_out_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
`ifdef DRAMSIM2_REFRESH_EN
    logic [RT_W-1:0]   ref_timer_q, ref_timer_d;
    logic [RC_W-1:0]   ref_cnt_q,   ref_cnt_d;
    logic              ref_pend_q,  ref_pend_d;
    logic              ref_hit;
`endif

    logic             full;
    logic             push;
    logic             complete;
    logic [PTR_W-1:0] next_ptr;
    logic [CNT_W-1:0] remaining;
    logic             next_avail;
    logic             next_wr;
    logic             can_start;
    logic             ref_take;
    logic             start;

    // Next-state logic: enqueue, completion, service start and refresh arbitration.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        tx_comp_d   = 1'b0;
        is_wr_out_d = is_wr_out_q;
        addr_out_d  = addr_out_q;
        ref_take    = 1'b0;

        full     = (count_q == CNT_W'(DEPTH));
        push     = TX_ENQ && !full;
        complete = (state_q == ST_BUSY) && (lat_cnt_q == LAT_W'(1));

        // The entry that would be serviced next, after any pop on this edge.
        // With nothing left in storage it is the request arriving this edge (bypass).
        next_ptr   = complete ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        remaining  = count_q - CNT_W'(complete);
        next_avail = (remaining != '0) || push;
        next_wr    = (remaining != '0) ? wr_mem_q[next_ptr] : IS_WR;
        can_start  = (state_q == ST_IDLE) || complete;

`ifdef DRAMSIM2_REFRESH_EN
        ref_hit     = (ref_timer_q == RT_W'(REF_INTERVAL - 1));
        ref_timer_d = ref_hit ? '0 : ref_timer_q + RT_W'(1);
        ref_take    = (ref_hit || ref_pend_q) && can_start;
        ref_pend_d  = (ref_hit || ref_pend_q) && !ref_take;
        ref_cnt_d   = ref_cnt_q;
`endif

        start = can_start && next_avail && !ref_take;

        if ((state_q == ST_BUSY) && !complete) begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end

        if (complete) begin
            state_d     = ST_IDLE;
            tx_comp_d   = 1'b1;
            addr_out_d  = addr_mem_q[rd_ptr_q];
            is_wr_out_d = wr_mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end

`ifdef DRAMSIM2_REFRESH_EN
        if (state_q == ST_REFRESH) begin
            if (ref_cnt_q == RC_W'(1)) begin
                state_d = ST_IDLE;
            end else begin
                ref_cnt_d = ref_cnt_q - RC_W'(1);
            end
        end
        if (ref_take) begin
            state_d   = ST_REFRESH;
            ref_cnt_d = RC_W'(REF_CYCLES);
        end
`endif

        if (start) begin
            state_d   = ST_BUSY;
            lat_cnt_d = next_wr ? LAT_W'(WRITE_LAT) : LAT_W'(READ_LAT);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, complete})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            tx_comp_q   <= 1'b0;
            is_wr_out_q <= 1'b0;
            addr_out_q  <= '0;
`ifdef DRAMSIM2_REFRESH_EN
            ref_timer_q <= '0;
            ref_cnt_q   <= '0;
            ref_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            tx_comp_q   <= tx_comp_d;
            is_wr_out_q <= is_wr_out_d;
            addr_out_q  <= addr_out_d;
`ifdef DRAMSIM2_REFRESH_EN
            ref_timer_q <= ref_timer_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
`endif
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count decide which entries are valid.
        if (push && !reset) begin
            addr_mem_q[wr_ptr_q] <= ADDR;
            wr_mem_q[wr_ptr_q]   <= IS_WR;
        end
    end

    assign TX_COMP   = tx_comp_q;
    assign IS_WR_OUT = is_wr_out_q;
    assign ADDR_OUT  = addr_out_q;
    assign FULL      = full;

endmodule

// File: tb/tb_dram_sim2.sv
// tb_dram_sim2: self-checking bench for dram_sim2.
// A transaction-level reference model predicts each request's completion edge
// from its enqueue edge and the previous completion; outputs are compared every cycle.
module tb_dram_sim2;

    localparam int ADDR_W    = 64;
    localparam int DEPTH     = 4;
    localparam int READ_LAT  = 10;
    localparam int WRITE_LAT = 6;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              tx_enq = 1'b0;
    logic              is_wr  = 1'b0;
    logic [ADDR_W-1:0] addr   = '0;
    logic              tx_comp;
    logic              is_wr_out;
    logic [ADDR_W-1:0] addr_out;
    logic              full;

    dram_sim2 #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT),
        .REF_INTERVAL(64), .REF_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .TX_ENQ(tx_enq), .IS_WR(is_wr), .ADDR(addr),
        .TX_COMP(tx_comp), .IS_WR_OUT(is_wr_out), .ADDR_OUT(addr_out), .FULL(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                comp;
        logic [ADDR_W-1:0] addr;
        logic              wr;
    } txn_t;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    int                last_comp = 0;
    txn_t              pend[$];
    int                pulses[$];
    logic [ADDR_W-1:0] pulse_addr[$];
    logic              exp_comp = 1'b0;
    logic              exp_wr   = 1'b0;
    logic              exp_full = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;

    task automatic check(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample 1 time unit later.
    task automatic tick(input logic rst, input logic enq, input logic wr, input logic [ADDR_W-1:0] a);
        txn_t t;
        reset  = rst;
        tx_enq = enq;
        is_wr  = wr;
        addr   = a;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            exp_comp  = 1'b0;
            exp_wr    = 1'b0;
            exp_addr  = '0;
            last_comp = 0;
        end else begin
            if (enq && (pend.size() < DEPTH)) begin
                t.comp    = ((cyc > last_comp) ? cyc : last_comp) + (wr ? WRITE_LAT : READ_LAT);
                t.addr    = a;
                t.wr      = wr;
                last_comp = t.comp;
                pend.push_back(t);
            end
            exp_comp = (pend.size() > 0) && (pend[0].comp == cyc);
            if (exp_comp) begin
                exp_addr = pend[0].addr;
                exp_wr   = pend[0].wr;
                void'(pend.pop_front());
            end
        end
        exp_full = (pend.size() == DEPTH);
        #1;
`ifndef DRAMSIM2_REFRESH_EN
        check("tx_comp",   {63'd0, tx_comp},   {63'd0, exp_comp});
        check("is_wr_out", {63'd0, is_wr_out}, {63'd0, exp_wr});
        check("addr_out",  addr_out,           exp_addr);
        check("full",      {63'd0, full},      {63'd0, exp_full});
`endif
        if (tx_comp) begin
            pulses.push_back(cyc);
            pulse_addr.push_back(addr_out);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0);
    endtask

    function automatic int pulse_at(input int i);
        return (i < pulses.size()) ? pulses[i] : -1;
    endfunction

    function automatic logic [ADDR_W-1:0] paddr_at(input int i);
        return (i < pulse_addr.size()) ? pulse_addr[i] : '1;
    endfunction

    initial begin
        int t0;
        int r;

        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 64'hDEAD);   // enqueue on a reset edge is ignored
        check("rst_tx_comp", {63'd0, tx_comp}, 64'd0);
        check("rst_full",    {63'd0, full},    64'd0);
        check("rst_addr",    addr_out,         64'd0);

`ifdef DRAMSIM2_REFRESH_EN
        // Refresh taken at edge 63 delays the read enqueued on that edge.
        pulses.delete(); pulse_addr.delete();
        t0 = cyc;
        idle(63);
        tick(1'b0, 1'b1, 1'b0, 64'h2000);
        idle(25);
        check("ref_npulse", 64'(pulses.size()), 64'd1);
        check("ref_edge",   64'(pulse_at(0)),   64'(t0 + 82));
        check("ref_addr",   paddr_at(0),        64'h2000);
        check("ref_wr",     {63'd0, is_wr_out}, 64'd0);
`else
        // Single read.
        pulses.delete(); pulse_addr.delete();
        t0 = cyc;
        tick(1'b0, 1'b1, 1'b0, 64'h1000);
        idle(12);
        check("rd_npulse", 64'(pulses.size()), 64'd1);
        check("rd_edge",   64'(pulse_at(0)),   64'(t0 + READ_LAT));
        check("rd_addr",   addr_out,           64'h1000);
        idle(5);
        check("rd_hold_addr", addr_out,           64'h1000);
        check("rd_hold_wr",   {63'd0, is_wr_out}, 64'd0);

        // Single write.
        pulses.delete(); pulse_addr.delete();
        t0 = cyc;
        tick(1'b0, 1'b1, 1'b1, 64'hABCD);
        idle(10);
        check("wr_edge", 64'(pulse_at(0)),   64'(t0 + WRITE_LAT));
        check("wr_type", {63'd0, is_wr_out}, 64'd1);
        check("wr_addr", addr_out,           64'hABCD);

        // Back-to-back reads.
        pulses.delete(); pulse_addr.delete();
        t0 = cyc;
        tick(1'b0, 1'b1, 1'b0, 64'h10);
        tick(1'b0, 1'b1, 1'b0, 64'h20);
        tick(1'b0, 1'b1, 1'b0, 64'h30);
        idle(35);
        check("b2b_npulse", 64'(pulses.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_edge", 64'(pulse_at(i)), 64'(t0 + READ_LAT * (i + 1)));
            check("b2b_addr", paddr_at(i),      64'(16 * (i + 1)));
        end

        // Overflow: the fifth request is dropped.
        pulses.delete(); pulse_addr.delete();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'(i % 2), 64'(256 + i));
            if (i == 2) check("ovf_full2", {63'd0, full}, 64'd0);
            if (i == 3) check("ovf_full3", {63'd0, full}, 64'd1);
        end
        idle(50);
        check("ovf_npulse", 64'(pulses.size()), 64'd4);
        check("ovf_last",   paddr_at(3),        64'd259);

        // Reset mid-service aborts the transaction.
        pulses.delete(); pulse_addr.delete();
        t0 = cyc;
        tick(1'b0, 1'b1, 1'b0, 64'h5000);
        idle(4);
        tick(1'b1, 1'b1, 1'b1, 64'h6000);
        check("mid_rst_comp", {63'd0, tx_comp},   64'd0);
        check("mid_rst_wr",   {63'd0, is_wr_out}, 64'd0);
        check("mid_rst_addr", addr_out,           64'd0);
        idle(1);
        tick(1'b0, 1'b1, 1'b0, 64'h7000);
        idle(14);
        check("mid_rst_npulse", 64'(pulses.size()), 64'd1);
        check("mid_rst_edge",   64'(pulse_at(0)),   64'(t0 + 17));
        check("mid_rst_addr2",  paddr_at(0),        64'h7000);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(99));
            tick(r < 2, r >= 45, 1'($urandom_range(1)), {$urandom, $urandom});
        end
        idle(45);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
